epu_sram_arbiter: RTL and testbench

//  Shares the single EPU system SRAM port (Image0/Weight/Image1 banks) between two requesters:
//  r0 = AXI slave side (host loads/readback), r1 = preload DMA engine. Decodes bank from addr[18:16],

---
 rtl/epu_sram_pkg.sv | 28 ++
 rtl/epu_bank_decode.sv | 34 +++
 rtl/epu_sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_epu_sram_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/epu_sram_pkg.sv
// rtl/epu_sram_pkg.sv - shared types and bank selector codes for the EPU SRAM arbiter
package epu_sram_pkg;

   typedef enum logic [1:0] {
      BANK_IMAGE0,
      BANK_WEIGHT,
      BANK_IMAGE1,
      BANK_NONE
   } bank_e;

   localparam logic [2:0] BANK_SEL_IMAGE0 = 3'b011;
   localparam logic [2:0] BANK_SEL_WEIGHT = 3'b100;
   localparam logic [2:0] BANK_SEL_IMAGE1 = 3'b101;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_OWN0,
      ARB_OWN1
   } arb_state_e;

   // One outstanding beat: rd = read data due, err = undecoded address, owner = requester index
   typedef struct packed {
      logic rd;
      logic err;
      logic owner;
   } pipe_t;

endpackage

// File: rtl/epu_bank_decode.sv
// rtl/epu_bank_decode.sv - address bank selector to bank id and active-low chip enables
module epu_bank_decode
   import epu_sram_pkg::*;
(
   input  logic [2:0] bank_sel,
   output bank_e      bank,
   output logic [2:0] ceb
);

   // ceb[0]=image0, ceb[1]=weight, ceb[2]=image1
   always_comb begin
      bank = BANK_NONE;
      ceb  = 3'b111;
      case (bank_sel)
         BANK_SEL_IMAGE0: begin
            bank = BANK_IMAGE0;
            ceb  = 3'b110;
         end
         BANK_SEL_WEIGHT: begin
            bank = BANK_WEIGHT;
            ceb  = 3'b101;
         end
         BANK_SEL_IMAGE1: begin
            bank = BANK_IMAGE1;
            ceb  = 3'b011;
         end
         default: begin
            bank = BANK_NONE;
            ceb  = 3'b111;
         end
      endcase
   end

endmodule

// File: rtl/epu_sram_arbiter.sv
// rtl/epu_sram_arbiter.sv - two-requester burst-locked round-robin arbiter for the EPU system SRAM
module epu_sram_arbiter
   import epu_sram_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int SRAM_AW = 14
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               epu_busy,
   input  logic               r0_req,
   input  logic               r0_last,
   input  logic               r0_we,
   input  logic [ADDR_W-1:0]  r0_addr,
   input  logic [DATA_W-1:0]  r0_wdata,
   output logic               r0_gnt,
   output logic               r0_rvalid,
   output logic [DATA_W-1:0]  r0_rdata,
   output logic               r0_err,
   input  logic               r1_req,
   input  logic               r1_last,
   input  logic               r1_we,
   input  logic [ADDR_W-1:0]  r1_addr,
   input  logic [DATA_W-1:0]  r1_wdata,
   output logic               r1_gnt,
   output logic               r1_rvalid,
   output logic [DATA_W-1:0]  r1_rdata,
   output logic               r1_err,
   output logic               sram_image0_ceb,
   output logic               sram_weight_ceb,
   output logic               sram_image1_ceb,
   output logic               sram_web,
   output logic [SRAM_AW-1:0] sram_a,
   output logic [DATA_W-1:0]  sram_di,
   input  logic [DATA_W-1:0]  sram_do
);

   arb_state_e          state;
   arb_state_e          state_nxt;
   logic                rr_ptr;
   logic                rr_ptr_nxt;
   pipe_t               pipe;
   pipe_t               pipe_nxt;

   logic                granted;
   logic                sel;
   logic                sel_we;
   logic                sel_last;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   bank_e               bank;
   logic [2:0]          bank_ceb;

   // Only word address and bank selector participate in decoding
   logic                unused_addr_bits;
   assign unused_addr_bits = ^{r0_addr[ADDR_W-1:19], r0_addr[1:0],
                               r1_addr[ADDR_W-1:19], r1_addr[1:0]};

   assign granted   = r0_gnt | r1_gnt;
   assign sel       = r1_gnt;
   assign sel_we    = sel ? r1_we    : r0_we;
   assign sel_last  = sel ? r1_last  : r0_last;
   assign sel_addr  = sel ? r1_addr  : r0_addr;
   assign sel_wdata = sel ? r1_wdata : r0_wdata;

   epu_bank_decode u_bank_decode (
      .bank_sel (sel_addr[18:16]),
      .bank     (bank),
      .ceb      (bank_ceb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ARB_IDLE;
         rr_ptr <= 1'b0;
         pipe   <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         pipe   <= pipe_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      if (granted) begin
         if (sel_last) begin
            state_nxt  = ARB_IDLE;
            rr_ptr_nxt = ~sel;
         end else begin
            state_nxt  = sel ? ARB_OWN1 : ARB_OWN0;
         end
      end
      // Pipe advances every cycle so a read already in flight completes even under epu_busy
      pipe_nxt.rd    = granted & ~sel_we;
      pipe_nxt.err   = granted & (bank == BANK_NONE);
      pipe_nxt.owner = sel;
   end

   always_comb begin
      r0_gnt = 1'b0;
      r1_gnt = 1'b0;
      if (!epu_busy) begin
         case (state)
            ARB_IDLE: begin
               if (rr_ptr == 1'b0) begin
                  r0_gnt = r0_req;
                  r1_gnt = r1_req & ~r0_req;
               end else begin
                  r1_gnt = r1_req;
                  r0_gnt = r0_req & ~r1_req;
               end
            end
            ARB_OWN0: r0_gnt = r0_req;
            ARB_OWN1: r1_gnt = r1_req;
            default: begin
               r0_gnt = 1'b0;
               r1_gnt = 1'b0;
            end
         endcase
      end

      sram_image0_ceb = 1'b1;
      sram_weight_ceb = 1'b1;
      sram_image1_ceb = 1'b1;
      sram_web        = 1'b1;
      sram_a          = '0;
      sram_di         = '0;
      if (r0_gnt | r1_gnt) begin
         sram_image0_ceb = bank_ceb[0];
         sram_weight_ceb = bank_ceb[1];
         sram_image1_ceb = bank_ceb[2];
         sram_web        = ~sel_we;
         sram_a          = sel_addr[SRAM_AW+1:2];
         sram_di         = sel_wdata;
      end

      r0_rvalid = pipe.rd  & ~pipe.owner;
      r1_rvalid = pipe.rd  &  pipe.owner;
      r0_err    = pipe.err & ~pipe.owner;
      r1_err    = pipe.err &  pipe.owner;
      r0_rdata  = (r0_rvalid && !pipe.err) ? sram_do : '0;
      r1_rdata  = (r1_rvalid && !pipe.err) ? sram_do : '0;
   end

endmodule

// File: tb/tb_epu_sram_arbiter.sv
// tb/tb_epu_sram_arbiter.sv - directed self-checking bench for epu_sram_arbiter
module tb_epu_sram_arbiter;

   logic        clk;
   logic        rst;
   logic        epu_busy;
   logic        r0_req, r0_last, r0_we, r0_gnt, r0_rvalid, r0_err;
   logic [31:0] r0_addr, r0_wdata, r0_rdata;
   logic        r1_req, r1_last, r1_we, r1_gnt, r1_rvalid, r1_err;
   logic [31:0] r1_addr, r1_wdata, r1_rdata;
   logic        sram_image0_ceb, sram_weight_ceb, sram_image1_ceb, sram_web;
   logic [13:0] sram_a;
   logic [31:0] sram_di, sram_do;
   logic [2:0]  ceb;

   int tests = 0;
   int fails = 0;

   assign ceb = {sram_image1_ceb, sram_weight_ceb, sram_image0_ceb};

   epu_sram_arbiter #(.DATA_W(32), .ADDR_W(32), .SRAM_AW(14)) dut (
      .clk             (clk),
      .rst             (rst),
      .epu_busy        (epu_busy),
      .r0_req          (r0_req),
      .r0_last         (r0_last),
      .r0_we           (r0_we),
      .r0_addr         (r0_addr),
      .r0_wdata        (r0_wdata),
      .r0_gnt          (r0_gnt),
      .r0_rvalid       (r0_rvalid),
      .r0_rdata        (r0_rdata),
      .r0_err          (r0_err),
      .r1_req          (r1_req),
      .r1_last         (r1_last),
      .r1_we           (r1_we),
      .r1_addr         (r1_addr),
      .r1_wdata        (r1_wdata),
      .r1_gnt          (r1_gnt),
      .r1_rvalid       (r1_rvalid),
      .r1_rdata        (r1_rdata),
      .r1_err          (r1_err),
      .sram_image0_ceb (sram_image0_ceb),
      .sram_weight_ceb (sram_weight_ceb),
      .sram_image1_ceb (sram_image1_ceb),
      .sram_web        (sram_web),
      .sram_a          (sram_a),
      .sram_di         (sram_di),
      .sram_do         (sram_do)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change 1ns after the rising edge; outputs sampled 1ns later, mid-cycle
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      epu_busy = 0;
      r0_req = 0; r0_last = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
      r1_req = 0; r1_last = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
      sram_do = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      cyc();
      cyc();
      #1;
      tests++; if ({r0_gnt, r1_gnt} !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", {r0_gnt, r1_gnt}); end
      tests++; if ({r0_rvalid, r1_rvalid, r0_err, r1_err} !== 4'b0000) begin fails++; $display("FAIL reset_rvalid_err: got %b want 0000", {r0_rvalid, r1_rvalid, r0_err, r1_err}); end
      tests++; if ({ceb, sram_web} !== 4'b1111) begin fails++; $display("FAIL reset_ceb_web: got %b want 1111", {ceb, sram_web}); end
      tests++; if (sram_a !== 14'h0 || sram_di !== 32'h0) begin fails++; $display("FAIL reset_a_di: got a=%h di=%h want 0 0", sram_a, sram_di); end
      tests++; if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h %h want 0 0", r0_rdata, r1_rdata); end
      rst = 0;
      cyc();
   endtask

   task automatic test_read();
      r0_req = 1; r0_we = 0; r0_last = 1; r0_addr = 32'h0003_0010;
      #1;
      tests++; if ({r0_gnt, r1_gnt} !== 2'b10) begin fails++; $display("FAIL read_gnt: got %b want 10", {r0_gnt, r1_gnt}); end
      tests++; if (ceb !== 3'b110) begin fails++; $display("FAIL read_ceb: got %b want 110", ceb); end
      tests++; if (sram_web !== 1'b1 || sram_a !== 14'h004) begin fails++; $display("FAIL read_web_a: got web=%b a=%h want 1 004", sram_web, sram_a); end
      cyc();
      r0_req = 0; r0_last = 0; sram_do = 32'h1234_5678;
      #1;
      tests++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h1234_5678) begin fails++; $display("FAIL read_rvalid: got v=%b d=%h want 1 12345678", r0_rvalid, r0_rdata); end
      tests++; if (r1_rvalid !== 1'b0 || r1_rdata !== 32'h0 || r0_err !== 1'b0) begin fails++; $display("FAIL read_other: got r1v=%b r1d=%h err=%b want 0 0 0", r1_rvalid, r1_rdata, r0_err); end
      cyc();
      tests++; if (r0_rvalid !== 1'b0) begin fails++; $display("FAIL read_pulse: got %b want 0", r0_rvalid); end
   endtask

   task automatic test_write();
      r0_req = 1; r0_we = 1; r0_last = 1; r0_addr = 32'h0005_0008; r0_wdata = 32'hDEAD_BEEF;
      #1;
      tests++; if (r0_gnt !== 1'b1 || ceb !== 3'b011) begin fails++; $display("FAIL write_gnt_ceb: got gnt=%b ceb=%b want 1 011", r0_gnt, ceb); end
      tests++; if (sram_web !== 1'b0 || sram_a !== 14'h002 || sram_di !== 32'hDEAD_BEEF) begin fails++; $display("FAIL write_drive: got web=%b a=%h di=%h want 0 002 deadbeef", sram_web, sram_a, sram_di); end
      cyc();
      idle_inputs();
      sram_do = 32'h5555_AAAA;
      #1;
      tests++; if (r0_rvalid !== 1'b0 || r0_rdata !== 32'h0) begin fails++; $display("FAIL write_no_rvalid: got v=%b d=%h want 0 0", r0_rvalid, r0_rdata); end
      cyc();
   endtask

   task automatic test_burst();
      rst = 1;
      cyc();
      rst = 0;
      r0_req = 1; r0_we = 0;
      r1_req = 1; r1_we = 0; r1_last = 1; r1_addr = 32'h0004_0040;
      for (int i = 0; i < 4; i++) begin
         r0_last = (i == 3);
         r0_addr = 32'h0003_0000 + 32'(4 * i);
         #1;
         tests++; if ({r0_gnt, r1_gnt} !== 2'b10 || sram_a !== 14'(i)) begin fails++; $display("FAIL burst_beat%0d: got gnt=%b a=%h want 10 %h", i, {r0_gnt, r1_gnt}, sram_a, i); end
         cyc();
      end
      r0_req = 0; r0_last = 0;
      #1;
      tests++; if ({r0_gnt, r1_gnt} !== 2'b01 || ceb !== 3'b101) begin fails++; $display("FAIL burst_handover: got gnt=%b ceb=%b want 01 101", {r0_gnt, r1_gnt}, ceb); end
      tests++; if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0) begin fails++; $display("FAIL burst_last_rvalid: got r0v=%b r1v=%b want 1 0", r0_rvalid, r1_rvalid); end
      cyc();
      r1_req = 0;
   endtask

   task automatic test_back_to_back();
      r0_req = 1; r0_we = 0; r0_last = 1; r0_addr = 32'h0004_0000;
      r1_req = 1; r1_we = 0; r1_last = 1; r1_addr = 32'h0004_0100;
      for (int i = 0; i < 4; i++) begin
         #1;
         tests++; if (r0_gnt !== (i % 2 == 0) || r1_gnt !== (i % 2 == 1)) begin fails++; $display("FAIL alt_gnt%0d: got %b want %b", i, {r0_gnt, r1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01); end
         tests++; if (ceb !== 3'b101) begin fails++; $display("FAIL alt_ceb%0d: got %b want 101", i, ceb); end
         if (i > 0) begin
            tests++; if (r0_rvalid !== (i % 2 == 1) || r1_rvalid !== (i % 2 == 0)) begin fails++; $display("FAIL alt_rvalid%0d: got %b", i, {r0_rvalid, r1_rvalid}); end
         end
         cyc();
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_error();
      r1_req = 1; r1_we = 0; r1_last = 1; r1_addr = 32'h0007_0000;
      #1;
      tests++; if (r1_gnt !== 1'b1 || ceb !== 3'b111) begin fails++; $display("FAIL err_gnt_ceb: got gnt=%b ceb=%b want 1 111", r1_gnt, ceb); end
      cyc();
      r1_req = 0; sram_do = 32'hCAFE_F00D;
      #1;
      tests++; if (r1_err !== 1'b1 || r1_rvalid !== 1'b1 || r1_rdata !== 32'h0) begin fails++; $display("FAIL err_resp: got err=%b v=%b d=%h want 1 1 0", r1_err, r1_rvalid, r1_rdata); end
      tests++; if (r0_err !== 1'b0 || r0_rvalid !== 1'b0) begin fails++; $display("FAIL err_other: got err=%b v=%b want 0 0", r0_err, r0_rvalid); end
      cyc();
      tests++; if (r1_err !== 1'b0) begin fails++; $display("FAIL err_pulse: got %b want 0", r1_err); end
      idle_inputs();
   endtask

   task automatic test_busy_and_reset();
      r1_req = 1; r1_we = 0; r1_last = 0; r1_addr = 32'h0004_0020;
      #1;
      tests++; if (r1_gnt !== 1'b1) begin fails++; $display("FAIL busy_first_beat: got %b want 1", r1_gnt); end
      cyc();
      epu_busy = 1;
      r0_req = 1; r0_we = 0; r0_last = 1; r0_addr = 32'h0003_0000;
      #1;
      tests++; if ({r0_gnt, r1_gnt} !== 2'b00 || ceb !== 3'b111 || sram_web !== 1'b1) begin fails++; $display("FAIL busy_block: got gnt=%b ceb=%b web=%b want 00 111 1", {r0_gnt, r1_gnt}, ceb, sram_web); end
      tests++; if (r1_rvalid !== 1'b1) begin fails++; $display("FAIL busy_inflight: got %b want 1", r1_rvalid); end
      cyc();
      epu_busy = 0; r1_req = 0;
      #1;
      tests++; if ({r0_gnt, r1_gnt} !== 2'b00 || ceb !== 3'b111) begin fails++; $display("FAIL busy_lock_held: got gnt=%b ceb=%b want 00 111", {r0_gnt, r1_gnt}, ceb); end
      cyc();
      r1_req = 1;
      #1;
      tests++; if ({r0_gnt, r1_gnt} !== 2'b01) begin fails++; $display("FAIL busy_resume: got %b want 01", {r0_gnt, r1_gnt}); end
      rst = 1;
      cyc();
      rst = 0; r1_req = 0;
      #1;
      tests++; if (r1_rvalid !== 1'b0 || r0_rvalid !== 1'b0) begin fails++; $display("FAIL rst_rvalid: got r0v=%b r1v=%b want 0 0", r0_rvalid, r1_rvalid); end
      tests++; if ({r0_gnt, r1_gnt} !== 2'b10) begin fails++; $display("FAIL rst_lock_dropped: got %b want 10", {r0_gnt, r1_gnt}); end
      cyc();
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_burst();
      test_back_to_back();
      test_error();
      test_busy_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
